// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: timing counters, RAM address generation and latency-matched colour output.
// Optional build macro VGA_TEST_PATTERN_EN adds a test_mode input selecting an 8-bar colour pattern.
module vga_scan_ctrl #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          SYNC_POL   = 1'b0,
    parameter int unsigned PIC_W      = 640,
    parameter int unsigned PIC_H      = 480,
    parameter int unsigned SCALE      = 1,
    parameter int unsigned RAM_LAT    = 1,
    parameter int unsigned ADDR_W     = 19,
    parameter logic [11:0] BORDER_RGB = 12'h000
) (
    input  logic              clk_V,
    input  logic              rst_n,
    input  logic              blank,
    input  logic [11:0]       pic_data_in,
`ifdef VGA_TEST_PATTERN_EN
    input  logic              test_mode,
`endif
    output logic [ADDR_W-1:0] ram_addr,
    output logic              HSYNC_V,
    output logic              VSYNC_V,
    output logic [3:0]        RED_V,
    output logic [3:0]        GREEN_V,
    output logic [3:0]        BLUE_V,
    output logic              de,
    output logic              frame_start
);

    localparam int unsigned H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned HA_START = H_SYNC + H_BP;
    localparam int unsigned VA_START = V_SYNC + V_BP;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned PIPE     = 1 + RAM_LAT;
    localparam int unsigned SH       = (SCALE == 2) ? 1 : 0;

    logic [HW-1:0]     h_cnt_q, h_cnt_d;
    logic [VW-1:0]     v_cnt_q, v_cnt_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [PIPE-1:0]   hs_p_q, vs_p_q, de_p_q, img_p_q, fs_p_q, blank_p_q;
    logic [PIPE-1:0]   hs_p_d, vs_p_d, de_p_d, img_p_d, fs_p_d, blank_p_d;
    logic [11:0]       rgb_q, rgb_d;
    logic              hsync_q, hsync_d, vsync_q, vsync_d, de_q, fs_q;

    logic [31:0] h_i, v_i, ax, ay, addr_full;
    logic        h_act, v_act, in_img;

    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (32'(h_cnt_q) == H_TOTAL - 1) begin
            h_cnt_d = '0;
            v_cnt_d = (32'(v_cnt_q) == V_TOTAL - 1) ? '0 : v_cnt_q + 1'b1;
        end
    end

    always_comb begin
        h_i       = 32'(h_cnt_q);
        v_i       = 32'(v_cnt_q);
        ax        = h_i - HA_START;
        ay        = v_i - VA_START;
        h_act     = (h_i >= HA_START) && (h_i < HA_START + H_ACTIVE);
        v_act     = (v_i >= VA_START) && (v_i < VA_START + V_ACTIVE);
        in_img    = h_act && v_act && (ax < PIC_W * SCALE) && (ay < PIC_H * SCALE);
        addr_full = (ay >> SH) * PIC_W + (ax >> SH);
        // Address only moves inside the image so the RAM sees no spurious reads in borders.
        ram_addr_d = in_img ? addr_full[ADDR_W-1:0] : ram_addr_q;
        hs_p_d     = {hs_p_q[PIPE-2:0], h_i < H_SYNC};
        vs_p_d     = {vs_p_q[PIPE-2:0], v_i < V_SYNC};
        de_p_d     = {de_p_q[PIPE-2:0], h_act && v_act};
        img_p_d    = {img_p_q[PIPE-2:0], in_img};
        fs_p_d     = {fs_p_q[PIPE-2:0], (h_i == 0) && (v_i == 0)};
        blank_p_d  = {blank_p_q[PIPE-2:0], blank};
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [7:0][11:0] BAR_RGB = {12'h000, 12'h00F, 12'hF00, 12'hF0F,
                                            12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF};
    logic [PIPE-1:0][2:0] bar_p_q;

    always_ff @(posedge clk_V or negedge rst_n) begin
        if (!rst_n) bar_p_q <= '0;
        else        bar_p_q <= {bar_p_q[PIPE-2:0], ax[9:7]};
    end
`endif

    always_comb begin
        rgb_d = 12'h000;
        if (de_p_q[PIPE-1] && !blank_p_q[PIPE-1]) begin
            rgb_d = img_p_q[PIPE-1] ? pic_data_in : BORDER_RGB;
`ifdef VGA_TEST_PATTERN_EN
            if (test_mode && img_p_q[PIPE-1]) rgb_d = BAR_RGB[bar_p_q[PIPE-1]];
`endif
        end
        hsync_d = hs_p_q[PIPE-1] ? SYNC_POL : ~SYNC_POL;
        vsync_d = vs_p_q[PIPE-1] ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk_V or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            ram_addr_q <= '0;
            hs_p_q     <= '0;
            vs_p_q     <= '0;
            de_p_q     <= '0;
            img_p_q    <= '0;
            fs_p_q     <= '0;
            blank_p_q  <= '0;
            rgb_q      <= '0;
            hsync_q    <= ~SYNC_POL;
            vsync_q    <= ~SYNC_POL;
            de_q       <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            ram_addr_q <= ram_addr_d;
            hs_p_q     <= hs_p_d;
            vs_p_q     <= vs_p_d;
            de_p_q     <= de_p_d;
            img_p_q    <= img_p_d;
            fs_p_q     <= fs_p_d;
            blank_p_q  <= blank_p_d;
            rgb_q      <= rgb_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            de_q       <= de_p_q[PIPE-1];
            fs_q       <= fs_p_q[PIPE-1];
        end
    end

    assign ram_addr    = ram_addr_q;
    assign HSYNC_V     = hsync_q;
    assign VSYNC_V     = vsync_q;
    assign RED_V       = rgb_q[11:8];
    assign GREEN_V     = rgb_q[7:4];
    assign BLUE_V      = rgb_q[3:0];
    assign de          = de_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Scoreboard bench for vga_scan_ctrl: two small-timing instances (SCALE 1 / SCALE 2) checked
// cycle by cycle against a behavioural model, plus sync/de counts and a mid-frame reset.
module tb_vga_scan_ctrl;

    localparam int HA = 16, HFP = 2, HS = 3, HB = 2;
    localparam int VA = 8,  VFP = 1, VS = 2, VB = 2;
    localparam int HT = HS + HB + HA + HFP;
    localparam int VT = VS + VB + VA + VFP;
    localparam int HAS = HS + HB;
    localparam int VAS = VS + VB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic blank = 1'b0;

    logic [11:0] data_a, data_b;
    logic [9:0]  addr_a;
    logic [7:0]  addr_b, b1;
    logic        hs_a, vs_a, de_a, fs_a, hs_b, vs_b, de_b, fs_b;
    logic [3:0]  r_a, g_a, bl_a, r_b, g_b, bl_b;
    logic [15:0] obs_a, obs_b;

    assign obs_a = {fs_a, de_a, hs_a, vs_a, r_a, g_a, bl_a};
    assign obs_b = {fs_b, de_b, hs_b, vs_b, r_b, g_b, bl_b};

    always #5 clk = ~clk;

    // RAM models returning data = address, latency 1 (A) and 2 (B).
    always @(posedge clk) begin
        data_a <= 12'(addr_a);
        b1     <= addr_b;
        data_b <= 12'(b1);
    end

    vga_scan_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .PIC_W(12), .PIC_H(6), .SCALE(1), .RAM_LAT(1),
        .ADDR_W(10), .BORDER_RGB(12'hF00)
    ) u_dut_a (
        .clk_V(clk), .rst_n(rst_n), .blank(blank), .pic_data_in(data_a),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(1'b0),
`endif
        .ram_addr(addr_a), .HSYNC_V(hs_a), .VSYNC_V(vs_a),
        .RED_V(r_a), .GREEN_V(g_a), .BLUE_V(bl_a), .de(de_a), .frame_start(fs_a)
    );

    vga_scan_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b1), .PIC_W(5), .PIC_H(3), .SCALE(2), .RAM_LAT(2),
        .ADDR_W(8), .BORDER_RGB(12'h0A5)
    ) u_dut_b (
        .clk_V(clk), .rst_n(rst_n), .blank(blank), .pic_data_in(data_b),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(1'b0),
`endif
        .ram_addr(addr_b), .HSYNC_V(hs_b), .VSYNC_V(vs_b),
        .RED_V(r_b), .GREEN_V(g_b), .BLUE_V(bl_b), .de(de_b), .frame_start(fs_b)
    );

    int errors = 0;
    int checks = 0;
    int mh, mv;
    logic [9:0]  held_a;
    logic [7:0]  held_b;
    logic [15:0] exp_a_q[$], exp_b_q[$];
    logic [9:0]  ea_q[$];
    logic [7:0]  eb_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [15:0] model_out(input int h, input int v, input logic blk,
                                              input int sc, input int pw, input int ph,
                                              input logic pol, input logic [11:0] border,
                                              output logic img, output int addr);
        int ax, ay;
        logic act;
        logic [11:0] rgb;
        ax   = h - HAS;
        ay   = v - VAS;
        act  = (h >= HAS) && (h < HAS + HA) && (v >= VAS) && (v < VAS + VA);
        img  = act && (ax < pw * sc) && (ay < ph * sc);
        addr = (ay / sc) * pw + ax / sc;
        rgb  = 12'h000;
        if (act && !blk) rgb = img ? 12'(addr) : border;
        return {(h == 0) && (v == 0), act, (h < HS) ? pol : ~pol, (v < VS) ? pol : ~pol, rgb};
    endfunction

    // Called at each negedge: drive blank, push expectations for the current counter
    // position, compare outputs whose latency has elapsed, then advance the model.
    task automatic step();
        logic img;
        int ad;
        blank = ($urandom_range(0, 9) == 0);
        exp_a_q.push_back(model_out(mh, mv, blank, 1, 12, 6, 1'b0, 12'hF00, img, ad));
        if (img) held_a = 10'(ad);
        ea_q.push_back(held_a);
        exp_b_q.push_back(model_out(mh, mv, blank, 2, 5, 3, 1'b1, 12'h0A5, img, ad));
        if (img) held_b = 8'(ad);
        eb_q.push_back(held_b);
        if (exp_a_q.size() == 4) check_eq("out_a", 32'(obs_a), 32'(exp_a_q.pop_front()));
        if (ea_q.size() == 2)    check_eq("addr_a", 32'(addr_a), 32'(ea_q.pop_front()));
        if (exp_b_q.size() == 5) check_eq("out_b", 32'(obs_b), 32'(exp_b_q.pop_front()));
        if (eb_q.size() == 2)    check_eq("addr_b", 32'(addr_b), 32'(eb_q.pop_front()));
        mh = mh + 1;
        if (mh == HT) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_a"}, 32'(obs_a), 32'({4'b0011, 12'h000}));
        check_eq({tag, "_b"}, 32'(obs_b), 32'({4'b0000, 12'h000}));
        check_eq({tag, "_addr_a"}, 32'(addr_a), 32'd0);
        check_eq({tag, "_addr_b"}, 32'(addr_b), 32'd0);
    endtask

    task automatic restart();
        exp_a_q.delete();
        exp_b_q.delete();
        ea_q.delete();
        eb_q.delete();
        held_a = '0;
        held_b = '0;
        mh = 0;
        mv = 0;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int de_a_cnt, de_b_cnt, hs_a_cnt, vs_a_cnt, hs_b_cnt, guard;
        de_a_cnt = 0; de_b_cnt = 0; hs_a_cnt = 0; vs_a_cnt = 0; hs_b_cnt = 0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        restart();
        for (int i = 1; i < 2 * HT * VT + 10; i++) begin
            @(negedge clk);
            if (i >= 10 && i < 10 + HT * VT) begin
                de_a_cnt += int'(de_a);
                de_b_cnt += int'(de_b);
                hs_a_cnt += int'(!hs_a);
                vs_a_cnt += int'(!vs_a);
                hs_b_cnt += int'(hs_b);
            end
            step();
        end
        check_eq("de_cnt_a", de_a_cnt, HA * VA);
        check_eq("de_cnt_b", de_b_cnt, HA * VA);
        check_eq("hs_low_a", hs_a_cnt, HS * VT);
        check_eq("vs_low_a", vs_a_cnt, VS * HT);
        check_eq("hs_high_b", hs_b_cnt, HS * VT);

        // Mid-frame reset inside the active area, held for three clocks.
        guard = 0;
        while (!(mh == 15 && mv == 6) && guard < HT * VT) begin
            @(negedge clk);
            step();
            guard++;
        end
        check_eq("reset_pos_reached", guard < HT * VT, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (3) begin
            @(negedge clk);
            check_reset_vals("midrst_hold");
        end
        restart();
        for (int i = 1; i < HT * VT + 10; i++) begin
            @(negedge clk);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
